// File: rtl/drum_pkg.sv
// Shared types and constants for the drum tone generator.
// State encoding is kept as plain localparam constants for compatibility with older tools.
package drum_pkg;

  typedef logic [1:0] tone_state_t;

  localparam tone_state_t StIdle   = 2'd0;
  localparam tone_state_t StSettle = 2'd1;
  localparam tone_state_t StPlay   = 2'd2;

  // Envelope start value; the envelope decays linearly from here to zero.
  localparam logic [7:0] AMP_MAX = 8'd255;

  // All pads released (the bus is active-low).
  localparam logic [4:0] PAD_IDLE = 5'b11111;

  // Square-wave sample: +/-(amp << 7), positive while the phase MSB is set.
  function automatic logic [15:0] square_sample(input logic msb, input logic [7:0] amp);
    logic [15:0] mag;
    mag = {1'b0, amp, 7'd0};
    return msb ? mag : (16'd0 - mag);
  endfunction

endpackage

// File: rtl/strobe_div.sv
// Free-running divide-by-DIV counter that emits a one-cycle strobe on its terminal count.
module strobe_div #(
  parameter int unsigned DIV = 4
) (
  input  logic clk,
  input  logic reset,
  output logic strobe
);

  localparam int unsigned CntW = (DIV > 1) ? $clog2(DIV) : 1;

  logic [CntW-1:0] cnt_q;

  // Strobe is high during the cycle the counter sits at its last value.
  assign strobe = (cnt_q == CntW'(DIV - 1));

  // Count up, wrapping to zero on the strobe.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else if (strobe) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

endmodule

// File: rtl/drum_tone_gen.sv
// Drum voice synthesiser: a pad hit starts a settle window, then the mixed frequency word is
// latched and drives a phase accumulator with a linearly decaying amplitude envelope.
// Optional: define DRUM_TONE_TRIANGLE_EN for a triangle-shaped Audio_Out (adds one multiplier);
// otherwise Audio_Out is a square wave. Tone_Out is a square wave in both builds.
module drum_tone_gen
  import drum_pkg::*;
#(
  parameter int unsigned ACC_W      = 26,
  parameter int unsigned SETTLE     = 8,
  parameter int unsigned SAMPLE_DIV = 1024,
  parameter int unsigned DECAY_DIV  = 65536
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] Freq_In,
  input  logic [4:0]  Pad_N,
  output logic [15:0] Audio_Out,
  output logic        Sample_Valid,
  output logic        Tone_Out,
  output logic        Busy
);

  localparam int unsigned SetW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

  tone_state_t       state_q, state_d;
  logic [SetW-1:0]   settle_q, settle_d;
  logic [ACC_W-1:0]  phase_q, phase_d;
  logic [ACC_W-1:0]  phase_step;
  logic [7:0]        amp_q, amp_d;
  logic [15:0]       incr_q, incr_d;
  logic              from_play_q, from_play_d;
  logic [4:0]        pad_q;
  logic              hit;
  logic              sample_stb;
  logic              decay_stb;
  logic [15:0]       audio_next;
  logic [15:0]       audio_q;
  logic              valid_q;
  logic              tone_q;
  logic              busy_q;

  strobe_div #(
    .DIV(SAMPLE_DIV)
  ) u_sample_div (
    .clk   (clk),
    .reset (reset),
    .strobe(sample_stb)
  );

  strobe_div #(
    .DIV(DECAY_DIV)
  ) u_decay_div (
    .clk   (clk),
    .reset (reset),
    .strobe(decay_stb)
  );

  // Any pad line falling 1->0 counts as a hit.
  assign hit        = |(pad_q & ~Pad_N);
  assign phase_step = phase_q + ACC_W'(incr_q);

  // Voice state machine: settle, latch frequency, play with decay, retrigger.
  always_comb begin
    state_d     = state_q;
    settle_d    = settle_q;
    phase_d     = phase_q;
    amp_d       = amp_q;
    incr_d      = incr_q;
    from_play_d = from_play_q;

    case (state_q)
      StIdle: begin
        if (hit) begin
          state_d     = StSettle;
          settle_d    = SetW'(SETTLE - 1);
          phase_d     = '0;
          from_play_d = 1'b0;
        end
      end

      StSettle: begin
        // A retriggered voice keeps ringing at its old pitch and held amplitude while settling.
        if (from_play_q) begin
          phase_d = phase_step;
        end
        if (hit) begin
          settle_d = SetW'(SETTLE - 1);
        end else if (settle_q == '0) begin
          if (Freq_In == 16'd0) begin
            state_d = StIdle;
            amp_d   = '0;
          end else begin
            incr_d  = Freq_In;
            amp_d   = AMP_MAX;
            state_d = StPlay;
          end
        end else begin
          settle_d = settle_q - 1'b1;
        end
      end

      StPlay: begin
        phase_d = phase_step;
        // A hit outranks a decay step landing on the same edge.
        if (hit) begin
          state_d     = StSettle;
          settle_d    = SetW'(SETTLE - 1);
          from_play_d = 1'b1;
        end else if (decay_stb) begin
          if (amp_q <= 8'd1) begin
            amp_d   = '0;
            state_d = StIdle;
          end else begin
            amp_d = amp_q - 1'b1;
          end
        end
      end

      default: begin
        state_d = StIdle;
        amp_d   = '0;
      end
    endcase
  end

  // Voice state registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= StIdle;
      settle_q    <= '0;
      phase_q     <= '0;
      amp_q       <= '0;
      incr_q      <= '0;
      from_play_q <= 1'b0;
      pad_q       <= PAD_IDLE;
    end else begin
      state_q     <= state_d;
      settle_q    <= settle_d;
      phase_q     <= phase_d;
      amp_q       <= amp_d;
      incr_q      <= incr_d;
      from_play_q <= from_play_d;
      pad_q       <= Pad_N;
    end
  end

`ifdef DRUM_TONE_TRIANGLE_EN
  logic [7:0]         tri8;
  logic signed [8:0]  tri_s;
  logic signed [9:0]  amp_s;
  logic signed [15:0] prod;
  logic [15:0]        prod_q;

  // Fold the phase into a triangle, centre it on zero, then scale by the envelope.
  assign tri8  = phase_q[ACC_W-1] ? ~phase_q[ACC_W-2 -: 8] : phase_q[ACC_W-2 -: 8];
  assign tri_s = $signed({1'b0, tri8}) - 9'sd128;
  assign amp_s = $signed({2'b00, amp_q});
  // Full product fits in 16 signed bits (-32640..32385), so truncation is exact.
  assign prod  = 16'(tri_s) * 16'(amp_s);

  // Pipeline the multiply one cycle ahead of the sample strobe.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prod_q <= '0;
    end else begin
      prod_q <= (state_q == StIdle) ? 16'd0 : prod;
    end
  end

  assign audio_next = prod_q;
`else
  assign audio_next = (state_q == StIdle) ? 16'd0 : square_sample(phase_q[ACC_W-1], amp_q);
`endif

  // Output registers: sample on strobe, tone and busy track the next voice state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      audio_q <= '0;
      valid_q <= 1'b0;
      tone_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      if (sample_stb) begin
        audio_q <= audio_next;
      end
      valid_q <= sample_stb;
      tone_q  <= phase_d[ACC_W-1] & (state_d == StPlay);
      busy_q  <= (state_d != StIdle);
    end
  end

  assign Audio_Out    = audio_q;
  assign Sample_Valid = valid_q;
  assign Tone_Out     = tone_q;
  assign Busy         = busy_q;

endmodule

// File: tb/tb_drum_tone_gen.sv
// Self-checking bench for drum_tone_gen: per-cycle comparison against a behavioural model,
// a table of directed segments, hand-written corner sequences and a randomized run.
module tb_drum_tone_gen;

  localparam int ACC_W      = 16;
  localparam int SETTLE     = 8;
  localparam int SAMPLE_DIV = 4;
  localparam int DECAY_DIV  = 2;
  localparam int PHASE_MOD  = 1 << ACC_W;
  localparam int HALF       = 1 << (ACC_W - 1);

  localparam int MIdle   = 0;
  localparam int MSettle = 1;
  localparam int MPlay   = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] Freq_In;
  logic [4:0]  Pad_N;
  logic [15:0] Audio_Out;
  logic        Sample_Valid;
  logic        Tone_Out;
  logic        Busy;

  int n_checks = 0;
  int n_errors = 0;
  int g_edges  = 0;

  // Reference model state (plain integers, counters derived from edges since reset).
  int m_st, m_cnt, m_phase, m_amp, m_incr, m_prev, m_from_play, m_k;
  int m_audio, m_valid, m_tone, m_busy, m_prod;

  typedef struct {
    logic [4:0]  pad;
    logic [15:0] freq;
    int          cycles;
    logic        exp_busy;
  } vec_t;

  vec_t vecs [10];

  always #5 clk = ~clk;

  drum_tone_gen #(
    .ACC_W     (ACC_W),
    .SETTLE    (SETTLE),
    .SAMPLE_DIV(SAMPLE_DIV),
    .DECAY_DIV (DECAY_DIV)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .Freq_In     (Freq_In),
    .Pad_N       (Pad_N),
    .Audio_Out   (Audio_Out),
    .Sample_Valid(Sample_Valid),
    .Tone_Out    (Tone_Out),
    .Busy        (Busy)
  );

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s at t=%0t: got %0d, expected %0d", name, $time, act, exp);
    end
  endtask

  function automatic int wave(input int phase, input int amp);
`ifdef DRUM_TONE_TRIANGLE_EN
    int t;
    t = (phase >> (ACC_W - 9)) & 255;
    if (phase >= HALF) t = 255 - t;
    return (t - 128) * amp;
`else
    return (phase >= HALF) ? amp * 128 : -(amp * 128);
`endif
  endfunction

  task automatic model_reset();
    m_st = MIdle; m_cnt = 0; m_phase = 0; m_amp = 0; m_incr = 0; m_prev = 31;
    m_from_play = 0; m_k = 0; m_audio = 0; m_valid = 0; m_tone = 0; m_busy = 0; m_prod = 0;
  endtask

  // One clock edge of the voice, as described behaviourally.
  task automatic model_edge(input int pad, input int freq);
    int hit, sstb, dstb, w;
    hit  = ((m_prev & ~pad) & 31) != 0;
    sstb = (m_k % SAMPLE_DIV) == SAMPLE_DIV - 1;
    dstb = (m_k % DECAY_DIV) == DECAY_DIV - 1;
    w    = (m_st == MIdle) ? 0 : wave(m_phase, m_amp);
`ifdef DRUM_TONE_TRIANGLE_EN
    if (sstb) m_audio = m_prod;
    m_prod = w;
`else
    if (sstb) m_audio = w;
`endif
    m_valid = sstb;
    if (m_st == MIdle) begin
      if (hit) begin
        m_st = MSettle; m_cnt = SETTLE - 1; m_phase = 0; m_from_play = 0;
      end
    end else if (m_st == MSettle) begin
      if (m_from_play) m_phase = (m_phase + m_incr) % PHASE_MOD;
      if (hit) m_cnt = SETTLE - 1;
      else if (m_cnt == 0) begin
        if (freq == 0) begin
          m_st = MIdle; m_amp = 0;
        end else begin
          m_incr = freq; m_amp = 255; m_st = MPlay;
        end
      end else m_cnt--;
    end else begin
      m_phase = (m_phase + m_incr) % PHASE_MOD;
      if (hit) begin
        m_st = MSettle; m_cnt = SETTLE - 1; m_from_play = 1;
      end else if (dstb) begin
        if (m_amp <= 1) begin
          m_amp = 0; m_st = MIdle;
        end else m_amp--;
      end
    end
    m_tone = (m_st == MPlay) && (m_phase >= HALF);
    m_busy = (m_st != MIdle);
    m_prev = pad & 31;
    m_k++;
  endtask

  task automatic step(input logic [4:0] pad, input logic [15:0] freq);
    Pad_N   = pad;
    Freq_In = freq;
    @(posedge clk);
    model_edge(int'(pad), int'(freq));
    g_edges++;
    #1;
    chk("audio", int'($signed(Audio_Out)), m_audio);
    chk("valid", int'(Sample_Valid), m_valid);
    chk("tone", int'(Tone_Out), m_tone);
    chk("busy", int'(Busy), m_busy);
  endtask

  // Assert reset between clock edges and confirm outputs clear without waiting for a clock.
  task automatic do_reset();
    #2;
    reset = 1'b1;
    Pad_N = 5'h1f;
    #1;
    chk("rst_audio", int'(Audio_Out), 0);
    chk("rst_valid", int'(Sample_Valid), 0);
    chk("rst_tone", int'(Tone_Out), 0);
    chk("rst_busy", int'(Busy), 0);
    @(posedge clk);
    #1;
    chk("rst_hold_busy", int'(Busy), 0);
    @(negedge clk);
    reset = 1'b0;
    model_reset();
  endtask

  task automatic wait_rise(input logic [4:0] pad, input logic [15:0] freq, input int bound,
                           output int idx);
    logic prev;
    idx  = -1;
    prev = Tone_Out;
    for (int i = 0; i < bound && idx < 0; i++) begin
      step(pad, freq);
      if (!prev && Tone_Out) idx = g_edges;
      prev = Tone_Out;
    end
    if (idx < 0) chk("tone_rise_timeout", 0, 1);
  endtask

  task automatic wait_valid(input logic [4:0] pad, input logic [15:0] freq, input int bound,
                            output int found);
    found = 0;
    for (int i = 0; i < bound && !found; i++) begin
      step(pad, freq);
      if (Sample_Valid) found = 1;
    end
    if (!found) chk("valid_timeout", 0, 1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int h, r1, r2, lat, found, cnt, nz, aud;
    logic [4:0]  rp;
    logic [15:0] rf;

    vecs[0] = '{5'h1f, 16'h1000, 10,  1'b0};
    vecs[1] = '{5'h1e, 16'h1000, 1,   1'b1};
    vecs[2] = '{5'h1e, 16'h1000, 7,   1'b1};
    vecs[3] = '{5'h1e, 16'h1000, 1,   1'b1};
    vecs[4] = '{5'h1e, 16'h5555, 100, 1'b1};
    vecs[5] = '{5'h1c, 16'h2000, 8,   1'b1};
    vecs[6] = '{5'h1c, 16'h2000, 600, 1'b0};
    vecs[7] = '{5'h1f, 16'h0000, 2,   1'b0};
    vecs[8] = '{5'h17, 16'h0000, 8,   1'b1};
    vecs[9] = '{5'h17, 16'h0000, 1,   1'b0};

    // Reset values.
    reset   = 1'b1;
    Pad_N   = 5'h1f;
    Freq_In = 16'h0;
    #1;
    chk("init_audio", int'(Audio_Out), 0);
    chk("init_valid", int'(Sample_Valid), 0);
    chk("init_tone", int'(Tone_Out), 0);
    chk("init_busy", int'(Busy), 0);
    @(negedge clk);
    reset = 1'b0;
    model_reset();

    // Idle: sample strobe free-runs every 4th cycle.
    cnt = 0;
    for (int i = 0; i < 16; i++) begin
      step(5'h1f, 16'h1000);
      cnt += int'(Sample_Valid);
    end
    chk("idle_valid_pulses", cnt, 4);

    // Directed segments.
    for (int i = 0; i < 10; i++) begin
      for (int c = 0; c < vecs[i].cycles; c++) step(vecs[i].pad, vecs[i].freq);
      chk($sformatf("tbl%0d_busy", i), int'(Busy), int'(vecs[i].exp_busy));
      if (!vecs[i].exp_busy) chk($sformatf("tbl%0d_tone", i), int'(Tone_Out), 0);
    end

    // Hit from idle: settle, first sample, tone period 16.
    step(5'h1f, 16'h1000);
    step(5'h1f, 16'h1000);
    step(5'h1e, 16'h1000);
    h = g_edges;
    chk("hit_busy", int'(Busy), 1);
    for (int i = 0; i < SETTLE; i++) step(5'h1e, 16'h1000);
    wait_valid(5'h1e, 16'h1000, 8, found);
    aud = int'($signed(Audio_Out));
    chk("first_sample_low_half", int'(aud <= -32384 && aud >= -32640), 1);
    wait_rise(5'h1e, 16'h1000, 40, r1);
    chk("first_rise_from_hit", r1 - h, 16);
    wait_rise(5'h1e, 16'h1000, 40, r2);
    chk("tone_period_16", r2 - r1, 16);

    // Retrigger 100 cycles into PLAY with a new pitch.
    for (int i = 0; i < 200 && g_edges < h + SETTLE + 100; i++) step(5'h1e, 16'h1000);
    for (int i = 0; i < SETTLE + 1; i++) step(5'h1c, 16'h2000);
    lat = g_edges;
    chk("retrig_busy", int'(Busy), 1);
    wait_valid(5'h1c, 16'h2000, 8, found);
    aud = int'($signed(Audio_Out));
    if (aud < 0) aud = -aud;
    chk("retrig_full_amp", int'(aud >= 32384 && aud <= 32640), 1);
    wait_rise(5'h1c, 16'h2000, 20, r1);
    wait_rise(5'h1c, 16'h2000, 20, r2);
    chk("tone_period_8", r2 - r1, 8);

    // Full decay: 255 strobes, every second cycle.
    found = 0;
    for (int i = 0; i < 600 && !found; i++) begin
      step(5'h1c, 16'h2000);
      if (!Busy) found = 1;
    end
    chk("decay_len", int'((g_edges - lat == 509) || (g_edges - lat == 510)), 1);
    for (int i = 0; i < SAMPLE_DIV; i++) step(5'h1c, 16'h2000);
    chk("post_decay_audio", int'(Audio_Out), 0);
    chk("post_decay_tone", int'(Tone_Out), 0);

    // Reset mid-PLAY, then a fresh hit gets a full settle with phase from zero.
    step(5'h1f, 16'h1000);
    step(5'h1e, 16'h1000);
    for (int i = 0; i < 20; i++) step(5'h1e, 16'h1000);
    chk("pre_reset_busy", int'(Busy), 1);
    do_reset();
    step(5'h1f, 16'h1000);
    step(5'h1f, 16'h1000);
    step(5'h1e, 16'h1000);
    h = g_edges;
    wait_rise(5'h1e, 16'h1000, 40, r1);
    chk("after_reset_first_rise", r1 - h, 16);

    // Zero frequency at the latch: back to idle, silent throughout.
    do_reset();
    step(5'h1f, 16'h0000);
    step(5'h1f, 16'h0000);
    cnt = 0;
    nz  = 0;
    for (int i = 0; i < 12; i++) begin
      step((i == 0) ? 5'h1e : 5'h1e, 16'h0000);
      cnt += int'(Busy);
      nz  += int'(Audio_Out != 16'h0);
    end
    chk("zero_freq_busy_cycles", cnt, SETTLE);
    chk("zero_freq_silent", nz, 0);

    // Randomized run against the model.
    rp = 5'h1f;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(199, 0) == 0) rp = 5'($urandom);
      rf = ($urandom_range(7, 0) == 0) ? 16'h0 : 16'($urandom);
      step(rp, rf);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
